// File: rtl/key_event_gen_pkg.sv
// ============================================================================
// Package : key_pkg
// Brief   : Shared FSM state encoding and default timing constants for the
//           key_event_gen push-button event generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  // Explicit 3-bit encoding keeps the state register width fixed
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    LONG       = 3'd3,
    RELEASE_DB = 3'd4
  } key_state_t;

  // 20 ms debounce at 50 MHz
  localparam logic [19:0] CNT_MAX_DEFAULT    = 20'd999_999;
  // 1 s from press confirmation to long-press event
  localparam logic [25:0] LONG_MAX_DEFAULT   = 26'd49_999_999;
  // 200 ms auto-repeat period
  localparam logic [23:0] REPEAT_MAX_DEFAULT = 24'd9_999_999;

endpackage

`default_nettype wire

// File: rtl/key_event_gen_if.sv
// ============================================================================
// Interface: key_event_gen_if
// Brief    : Raw key input and debounced event outputs of key_event_gen.
//            The slave modport is taken by the generator, the master modport
//            by whatever drives the button and consumes the events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_event_gen_if;

  logic key_in;     // raw button, active-low
  logic key_flag;   // one-cycle pulse on debounced press
  logic key_long;   // one-cycle pulse on long press
  logic key_rpt;    // one-cycle auto-repeat pulse
  logic key_level;  // debounced level, 1 = pressed

  modport master (
    output key_in,
    input  key_flag,
    input  key_long,
    input  key_rpt,
    input  key_level
  );

  modport slave (
    input  key_in,
    output key_flag,
    output key_long,
    output key_rpt,
    output key_level
  );

endinterface

`default_nettype wire

// File: rtl/key_event_gen_sync.sv
// ============================================================================
// Module  : key_sync
// Brief   : Two-flop synchronizer for the asynchronous push-button input.
//           Both flops reset to 1 (the released level of an active-low key)
//           so that no false press is seen coming out of reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_sync (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic async_in,
  output logic      sync_out
);

  logic meta;

  // Two-stage resynchronisation into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event_gen.sv
// ============================================================================
// Module  : key_event_gen
// Brief   : Debounced push-button event generator. Produces a press pulse
//           (key_flag), a long-press pulse (key_long), optional auto-repeat
//           pulses (key_rpt) and the debounced pressed level (key_level).
//           Build macro KEY_REPEAT_EN enables the auto-repeat counter; when
//           it is undefined key_rpt is tied low and LONG only waits for
//           release.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_gen
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_MAX_DEFAULT,
  parameter int unsigned LONG_MAX   = LONG_MAX_DEFAULT,
  parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEFAULT
) (
  input wire logic       clk,
  input wire logic       reset,
  key_event_gen_if.slave bus
);

  localparam int DBC_W  = $clog2(CNT_MAX + 1);
  localparam int HOLD_W = $clog2(LONG_MAX + 1);

  localparam logic [DBC_W-1:0]  DBC_LAST = DBC_W'(CNT_MAX);
  // Hold counter lands exactly on LONG_MAX in the cycle key_long is issued,
  // so the long event shows LONG_MAX cycles after key_flag.
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(LONG_MAX);

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_MAX + 1);
  // Repeat counter runs 0..REPEAT_MAX-1 and wraps, giving one key_rpt
  // every REPEAT_MAX cycles measured from key_long.
  localparam logic [RPT_W-1:0] RPT_PRE = RPT_W'(REPEAT_MAX - 1);
`endif

  key_state_t        state;
  logic              key_s;       // synchronized key, active-low
  logic [DBC_W-1:0]  dbc_cnt;     // press/release debounce counter
  logic [HOLD_W-1:0] hold_cnt;    // cycles held since press confirmation
  logic              from_long;   // RELEASE_DB entered from LONG
  logic              flag_q;
  logic              long_q;
  logic              level_q;
  logic              rpt_w;

`ifdef KEY_REPEAT_EN
  logic [RPT_W-1:0]  rpt_cnt;
  logic              rpt_q;
`endif

  key_sync u_key_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.key_in),
    .sync_out (key_s)
  );

  // Press/hold/release state machine with registered event outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dbc_cnt   <= '0;
      hold_cnt  <= '0;
      from_long <= 1'b0;
      flag_q    <= 1'b0;
      long_q    <= 1'b0;
      level_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_q     <= 1'b0;
`endif
    end else begin
      // Event outputs are single-cycle pulses by default
      flag_q <= 1'b0;
      long_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!key_s) begin
            state   <= PRESS_DB;
            dbc_cnt <= '0;
          end
        end

        PRESS_DB: begin
          if (key_s) begin
            state   <= IDLE;
            dbc_cnt <= '0;
          end else if (dbc_cnt == DBC_LAST) begin
            state    <= HELD;
            dbc_cnt  <= '0;
            hold_cnt <= '0;
            flag_q   <= 1'b1;
            level_q  <= 1'b1;
          end else begin
            dbc_cnt <= dbc_cnt + 1'b1;
          end
        end

        HELD: begin
          if (key_s) begin
            // Hold counter freezes while the release is being qualified
            state     <= RELEASE_DB;
            dbc_cnt   <= '0;
            from_long <= 1'b0;
          end else if (hold_cnt == HOLD_PRE) begin
            state    <= LONG;
            hold_cnt <= HOLD_END;
            long_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        LONG: begin
          if (key_s) begin
            state     <= RELEASE_DB;
            dbc_cnt   <= '0;
            from_long <= 1'b1;
          end
`ifdef KEY_REPEAT_EN
          else if (rpt_cnt == RPT_PRE) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end

        RELEASE_DB: begin
          if (!key_s) begin
            // Bounce on release: resume where we left off, no new press
            state   <= from_long ? LONG : HELD;
            dbc_cnt <= '0;
          end else if (dbc_cnt == DBC_LAST) begin
            state     <= IDLE;
            dbc_cnt   <= '0;
            hold_cnt  <= '0;
            from_long <= 1'b0;
            level_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
`endif
          end else begin
            dbc_cnt <= dbc_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          dbc_cnt <= '0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  assign rpt_w = rpt_q;
`else
  assign rpt_w = 1'b0;
`endif

  assign bus.key_flag  = flag_q;
  assign bus.key_long  = long_q;
  assign bus.key_rpt   = rpt_w;
  assign bus.key_level = level_q;

  // Event pulses never coincide
  a_pulse_excl: assert property (@(posedge clk) disable iff (reset)
    $onehot0({flag_q, long_q, rpt_w}));

  // Counters stay inside their configured range
  a_cnt_range: assert property (@(posedge clk) disable iff (reset)
    (dbc_cnt <= DBC_LAST) && (hold_cnt <= HOLD_END));

  // Timing parameters must all be non-zero
  a_param_ok: assert property (@(posedge clk)
    (CNT_MAX > 0) && (LONG_MAX > 0) && (REPEAT_MAX > 0));

endmodule

`default_nettype wire
